// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI responder register block.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    PAR,
    COMMIT,
    TURN,
    RDATA,
    WAITCS
  } state_t;

  localparam logic CMD_WR = 1'b1;
  localparam logic CMD_RD = 1'b0;
  localparam int   ADDR_W = 8;
  localparam int   DATA_W = 8;

  // Even parity bit that makes the total count of ones over addr+data+bit even.
  function automatic logic even_par(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    return ^{a, d};
  endfunction

endpackage

// File: rtl/spi_resp_regs_if.sv
// SPI link (cs/mosi/miso) plus the local-side strobes and last-access status.
interface spi_resp_regs_if;
  import spi_pkg::*;

  logic              cs;
  logic              mosi;
  logic              miso;
  logic              wr_done;
  logic              rd_done;
  logic              err;
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] last_data;

  modport master (
    output cs, mosi,
    input  miso, wr_done, rd_done, err, last_addr, last_data
  );

  modport slave (
    input  cs, mosi,
    output miso, wr_done, rd_done, err, last_addr, last_data
  );
endinterface

// File: rtl/spi_resp_rf.sv
// NREGS x 8 register file: synchronous write, combinational read, reset to RST_VAL.
module spi_resp_rf
  import spi_pkg::*;
#(
  parameter int               NREGS   = 32,
  parameter logic [DATA_W-1:0] RST_VAL = 8'h00
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [DATA_W-1:0] r_mem [NREGS];
  logic              w_in_range;

  assign w_in_range = int'(i_addr) < NREGS;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= RST_VAL;
    end else if (i_we && w_in_range) begin
      r_mem[i_addr[IW-1:0]] <= i_wdata;
    end
  end

  // Out-of-range reads return zero so the serial shifter never sees stale data.
  assign o_rdata = w_in_range ? r_mem[i_addr[IW-1:0]] : '0;

endmodule

// File: rtl/spi_resp_regs.sv
// SPI responder with register bank. Define SPI_PARITY_EN to add an even-parity
// bit (over addr+data) to write frames.
module spi_resp_regs
  import spi_pkg::*;
#(
  parameter int               NREGS   = 32,
  parameter logic [DATA_W-1:0] RST_VAL = 8'h00
) (
  input  logic            clk,
  input  logic            rst,
  spi_resp_regs_if.slave  bus
);

  state_t            r_state;
  logic              r_cmd;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [2:0]        r_cnt;
  logic [6:0]        r_shift;
  logic              r_miso;
  logic              r_wr_done;
  logic              r_rd_done;
  logic              r_err;
  logic [ADDR_W-1:0] r_last_addr;
  logic [DATA_W-1:0] r_last_data;
`ifdef SPI_PARITY_EN
  logic              r_par;
`endif

  logic [DATA_W-1:0] w_rdata;
  logic              w_addr_ok;
  logic              w_par_ok;
  logic              w_commit_ok;
  logic              w_we;
  logic              w_abort;

  always_comb begin
    w_addr_ok = int'(r_addr) < NREGS;
`ifdef SPI_PARITY_EN
    w_par_ok  = (r_par == even_par(r_addr, r_data));
`else
    w_par_ok  = 1'b1;
`endif
    w_commit_ok = w_addr_ok && w_par_ok;
    w_we        = (r_state == COMMIT) && w_commit_ok;
    // COMMIT and WAITCS tolerate cs high; every shifting/turnaround state aborts.
    w_abort     = bus.cs && (r_state inside {ADDR, WDATA, PAR, TURN, RDATA});
  end

  spi_resp_rf #(
    .NREGS   (NREGS),
    .RST_VAL (RST_VAL)
  ) u_rf (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_we    (w_we),
    .i_addr  (r_addr),
    .i_wdata (r_data),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cmd       <= CMD_RD;
      r_addr      <= '0;
      r_data      <= '0;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_miso      <= 1'b0;
      r_wr_done   <= 1'b0;
      r_rd_done   <= 1'b0;
      r_err       <= 1'b0;
      r_last_addr <= '0;
      r_last_data <= '0;
`ifdef SPI_PARITY_EN
      r_par       <= 1'b0;
`endif
    end else begin
      r_wr_done <= 1'b0;
      r_rd_done <= 1'b0;
      r_err     <= 1'b0;
      if (w_abort) begin
        r_err   <= 1'b1;
        r_miso  <= 1'b0;
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            r_miso <= 1'b0;
            if (!bus.cs) begin
              r_cmd   <= bus.mosi;
              r_cnt   <= '0;
              r_state <= ADDR;
            end
          end
          ADDR: begin
            r_addr <= {r_addr[ADDR_W-2:0], bus.mosi};
            r_cnt  <= r_cnt + 3'd1;
            if (r_cnt == 3'd7) r_state <= (r_cmd == CMD_WR) ? WDATA : TURN;
          end
          WDATA: begin
            r_data <= {r_data[DATA_W-2:0], bus.mosi};
            r_cnt  <= r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
`ifdef SPI_PARITY_EN
              r_state <= PAR;
`else
              r_state <= COMMIT;
`endif
            end
          end
`ifdef SPI_PARITY_EN
          PAR: begin
            r_par   <= bus.mosi;
            r_state <= COMMIT;
          end
`endif
          COMMIT: begin
            if (w_commit_ok) begin
              r_wr_done   <= 1'b1;
              r_last_addr <= r_addr;
              r_last_data <= r_data;
            end else begin
              r_err <= 1'b1;
            end
            r_state <= WAITCS;
          end
          TURN: begin
            // miso is registered, so bit 7 is presented here and bits 6..0 follow from r_shift.
            r_shift <= w_rdata[6:0];
            r_miso  <= w_rdata[7];
            r_cnt   <= '0;
            if (!w_addr_ok) r_err <= 1'b1;
            r_state <= RDATA;
          end
          RDATA: begin
            r_miso  <= r_shift[6];
            r_shift <= {r_shift[5:0], 1'b0};
            r_cnt   <= r_cnt + 3'd1;
            if (r_cnt == 3'd6) begin
              r_rd_done <= 1'b1;
              if (w_addr_ok) begin
                r_last_addr <= r_addr;
                r_last_data <= w_rdata;
              end
            end
            if (r_cnt == 3'd7) begin
              r_miso  <= 1'b0;
              r_state <= WAITCS;
            end
          end
          WAITCS: begin
            r_miso <= 1'b0;
            if (bus.cs) r_state <= IDLE;
          end
          default: begin
            r_miso  <= 1'b0;
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.miso      = r_miso;
  assign bus.wr_done   = r_wr_done;
  assign bus.rd_done   = r_rd_done;
  assign bus.err       = r_err;
  assign bus.last_addr = r_last_addr;
  assign bus.last_data = r_last_data;

endmodule

// File: tb/tb_spi_resp_regs.sv
// Directed + randomized bench for spi_resp_regs with a frame-level reference model.
module tb_spi_resp_regs;

  localparam int         NREGS   = 32;
  localparam logic [7:0] RST_VAL = 8'h00;
`ifdef SPI_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  logic [7:0] mem [NREGS];
  logic [7:0] m_last_addr;
  logic [7:0] m_last_data;

  spi_resp_regs_if bus ();

  spi_resp_regs #(
    .NREGS   (NREGS),
    .RST_VAL (RST_VAL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic c, input logic m);
    bus.cs   = c;
    bus.mosi = m;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) mem[i] = RST_VAL;
    m_last_addr = 8'h00;
    m_last_data = 8'h00;
  endtask

  task automatic chk_last(input string tag);
    chk({tag, ".last_addr"}, bus.last_addr, m_last_addr);
    chk({tag, ".last_data"}, bus.last_data, m_last_data);
  endtask

  // Write frame: cmd, addr, data, optional parity; then one commit cycle, then cs high.
  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input bit bad_par);
    logic bits[$];
    int   n_bits;
    int   cyc;
    logic ok;
    logic p;
    bits.delete();
    bits.push_back(1'b1);
    for (int i = 7; i >= 0; i--) bits.push_back(a[i]);
    for (int i = 7; i >= 0; i--) bits.push_back(d[i]);
    p  = logic'($countones({a, d}) % 2) ^ logic'(bad_par);
    if (PAR_EN) bits.push_back(p);
    ok = (int'(a) < NREGS) && !(PAR_EN && bad_par);
    n_bits = bits.size();
    for (int t = 0; t <= n_bits; t++) begin
      tick(1'b0, (t < n_bits) ? bits[t] : logic'($urandom_range(0, 1)));
      cyc = t + 1;
      chk("wr.wr_done", {7'd0, bus.wr_done}, {7'd0, ok && (cyc == n_bits + 1)});
      chk("wr.err", {7'd0, bus.err}, {7'd0, !ok && (cyc == n_bits + 1)});
      chk("wr.miso", {7'd0, bus.miso}, 8'h00);
    end
    tick(1'b1, logic'($urandom_range(0, 1)));
    chk("wr.idle_wr_done", {7'd0, bus.wr_done}, 8'h00);
    if (ok) begin
      mem[a]      = d;
      m_last_addr = a;
      m_last_data = d;
    end
    chk_last("wr");
  endtask

  // Read frame: cmd, addr, turnaround, 8 miso bits; then cs high.
  task automatic do_read(input logic [7:0] a);
    logic       ok;
    logic [7:0] exp_d;
    logic [7:0] ab;
    logic       exp_miso;
    int         cyc;
    ok    = int'(a) < NREGS;
    exp_d = ok ? mem[a] : 8'h00;
    ab    = a;
    for (int t = 0; t < 18; t++) begin
      if (t == 0)     tick(1'b0, 1'b0);
      else if (t < 9) tick(1'b0, ab[8-t]);
      else            tick(1'b0, logic'($urandom_range(0, 1)));
      cyc = t + 1;
      exp_miso = (cyc >= 10 && cyc <= 17) ? exp_d[17-cyc] : 1'b0;
      chk("rd.miso", {7'd0, bus.miso}, {7'd0, exp_miso});
      chk("rd.rd_done", {7'd0, bus.rd_done}, {7'd0, cyc == 17});
      chk("rd.err", {7'd0, bus.err}, {7'd0, !ok && (cyc == 10)});
      chk("rd.wr_done", {7'd0, bus.wr_done}, 8'h00);
    end
    tick(1'b1, logic'($urandom_range(0, 1)));
    chk("rd.idle_miso", {7'd0, bus.miso}, 8'h00);
    if (ok) begin
      m_last_addr = a;
      m_last_data = exp_d;
    end
    chk_last("rd");
  endtask

  // Write frame cut short: cs rises after k bits (cmd counts as bit 0).
  task automatic do_abort(input logic [7:0] a, input logic [7:0] d, input int k);
    logic [16:0] bits;
    bits = {1'b1, a, d};
    for (int t = 0; t < k; t++) begin
      tick(1'b0, bits[16-t]);
      chk("ab.err_early", {7'd0, bus.err}, 8'h00);
    end
    tick(1'b1, logic'($urandom_range(0, 1)));
    chk("ab.err", {7'd0, bus.err}, 8'h01);
    chk("ab.wr_done", {7'd0, bus.wr_done}, 8'h00);
    chk("ab.miso", {7'd0, bus.miso}, 8'h00);
    tick(1'b1, 1'b0);
    chk("ab.err_clear", {7'd0, bus.err}, 8'h00);
    chk_last("ab");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    rst = 1'b0;
    model_reset();
    chk("rst.miso", {7'd0, bus.miso}, 8'h00);
    chk("rst.wr_done", {7'd0, bus.wr_done}, 8'h00);
    chk("rst.rd_done", {7'd0, bus.rd_done}, 8'h00);
    chk("rst.err", {7'd0, bus.err}, 8'h00);
    chk_last("rst");
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rd;
    int         op;
    n_cmp    = 0;
    n_bad    = 0;
    rst      = 1'b0;
    bus.cs   = 1'b1;
    bus.mosi = 1'b0;
    model_reset();

    do_reset();
    do_read(8'h05);

    do_write(8'h03, 8'hA5, 1'b0);
    do_read(8'h03);

    do_write(8'h40, 8'h77, 1'b0);
    do_read(8'h00);

    do_write(8'h01, 8'h55, 1'b0);
    do_abort(8'h01, 8'hC3, 14);
    do_read(8'h01);
    do_abort(8'h07, 8'h11, 4);
    do_write(8'h07, 8'h3C, 1'b0);
    do_read(8'h07);

    do_write(8'h00, 8'h96, 1'b0);
    do_write(8'h1F, 8'h6B, 1'b0);
    do_read(8'h00);
    do_read(8'h1F);
    do_read(8'h20);

`ifdef SPI_PARITY_EN
    do_write(8'h02, 8'h0F, 1'b1);
    do_read(8'h02);
    do_write(8'h02, 8'h0F, 1'b0);
    do_read(8'h02);
`endif

    for (int n = 0; n < 50; n++) begin
      op = int'($urandom_range(0, 9));
      ra = 8'($urandom_range(0, NREGS + 7));
      rd = 8'($urandom);
      if (op < 4)       do_write(ra, rd, 1'b0);
      else if (op == 4) do_write(ra, rd, 1'b1);
      else if (op < 9)  do_read(ra);
      else              do_abort(ra, rd, int'($urandom_range(1, 16)));
    end

    do_write(8'h09, 8'hE1, 1'b0);
    for (int t = 0; t < 12; t++) tick(1'b0, 1'b1);
    do_reset();
    do_read(8'h09);
    do_read(8'h03);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
